bram_fifo_ctrl: RTL and testbench



---
 rtl/bram_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around a registered-read dual-port RAM. A 2-entry output
// buffer absorbs the RAM read latency and presents a first-word-fall-through stream.

module bram_fifo_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic inflight,
    input logic bram_rdv
);
    // A read issued last cycle must come back now; stray rdv with nothing in flight is tolerated
    rdv_follows_ren: assert property (@(posedge clk) disable iff (rst) inflight |-> bram_rdv);
endmodule

module bram_fifo_ctrl #(
    parameter int DEPTH  = 16,
    parameter int DWIDTH = 32,
    localparam int AWIDTH = $clog2(DEPTH),
    localparam int CWIDTH = AWIDTH + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              bram_wen,
    output logic [AWIDTH-1:0] bram_waddr,
    output logic [DWIDTH-1:0] bram_wdata,
    output logic              bram_ren,
    output logic [AWIDTH-1:0] bram_raddr,
    input  logic              bram_rdv,
    input  logic [DWIDTH-1:0] bram_rdata,
    output logic [CWIDTH-1:0] count
);
    logic [AWIDTH-1:0] wptr_r;
    logic [AWIDTH-1:0] rptr_r;
    logic [CWIDTH-1:0] ram_cnt_r;
    logic [CWIDTH-1:0] count_r;
    logic              inflight_r;
    logic [1:0]        out_cnt_r;
    logic              s_ready_r;
    logic              m_valid_r;
    logic [DWIDTH-1:0] buf0_r;
    logic [DWIDTH-1:0] buf1_r;

    logic              push_s;
    logic              pop_s;
    logic              ren_s;
    logic [1:0]        occ_s;
    logic [1:0]        slot_s;
    logic [CWIDTH-1:0] ram_cnt_nxt_s;

    // Handshakes, read-issue decision and next occupancy
    always_comb begin
        push_s        = s_valid & s_ready_r;
        pop_s         = m_valid_r & m_ready;
        occ_s         = out_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
        ren_s         = (ram_cnt_r != '0) && (occ_s < 2'd2);
        slot_s        = out_cnt_r - {1'b0, pop_s};
        ram_cnt_nxt_s = ram_cnt_r + CWIDTH'(push_s) - CWIDTH'(ren_s);
    end

    // Pointers, occupancy counters and the registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            ram_cnt_r  <= '0;
            inflight_r <= 1'b0;
            out_cnt_r  <= 2'd0;
            s_ready_r  <= 1'b1;
            m_valid_r  <= 1'b0;
            count_r    <= '0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AWIDTH'(1);
            end
            if (ren_s) begin
                rptr_r <= rptr_r + AWIDTH'(1);
            end
            ram_cnt_r  <= ram_cnt_nxt_s;
            inflight_r <= ren_s;
            out_cnt_r  <= occ_s;
            s_ready_r  <= (ram_cnt_nxt_s != CWIDTH'(DEPTH));
            m_valid_r  <= (occ_s != 2'd0);
            count_r    <= ram_cnt_nxt_s + CWIDTH'(ren_s) + CWIDTH'(occ_s);
        end
    end

    // Output buffer: shift on pop, returning word lands in the first free slot
    always_ff @(posedge clk) begin
        if (pop_s) begin
            buf0_r <= buf1_r;
        end
        if (inflight_r) begin
            case (slot_s)
                2'd0:    buf0_r <= bram_rdata;
                2'd1:    buf1_r <= bram_rdata;
                default: ;
            endcase
        end
    end

    assign s_ready    = s_ready_r;
    assign m_valid    = m_valid_r;
    assign m_data     = buf0_r;
    assign count      = count_r;
    assign bram_wen   = push_s;
    assign bram_waddr = wptr_r;
    assign bram_wdata = s_data;
    assign bram_ren   = ren_s;
    assign bram_raddr = rptr_r;

    bram_fifo_ctrl_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .inflight (inflight_r),
        .bram_rdv (bram_rdv)
    );
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a registered-read RAM model and a
// data/count scoreboard checked every cycle.

module tb_bram_fifo_ctrl;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          bram_wen;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_wdata;
    logic          bram_ren;
    logic [AW-1:0] bram_raddr;
    logic          bram_rdv = 1'b0;
    logic [DW-1:0] bram_rdata = '0;
    logic [CW-1:0] count;

    logic [DW-1:0] mem [DEPTH];

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] sb [$];
    logic [AW-1:0] wptr_m = '0;
    logic [AW-1:0] rptr_m = '0;
    int            ram_m = 0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_val = '0;
    logic          last_push = 1'b0;
    logic          last_pop = 1'b0;
    int            acc;
    int            nxt;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.DEPTH(DEPTH), .DWIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .bram_wen   (bram_wen),
        .bram_waddr (bram_waddr),
        .bram_wdata (bram_wdata),
        .bram_ren   (bram_ren),
        .bram_raddr (bram_raddr),
        .bram_rdv   (bram_rdv),
        .bram_rdata (bram_rdata),
        .count      (count)
    );

    // Dual-port RAM with one-cycle registered read
    always @(posedge clk) begin
        if (bram_wen) mem[bram_waddr] <= bram_wdata;
        bram_rdv <= bram_ren;
        if (bram_ren) bram_rdata <= mem[bram_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_adv();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample: scoreboard bookkeeping plus per-cycle invariants
    task automatic samp();
        logic [DW-1:0] e;
        @(negedge clk);
        last_push = s_valid && s_ready;
        last_pop  = m_valid && m_ready;
        chk("count", count, sb.size());
        chk("s_ready", s_ready, ram_m != DEPTH);
        chk("wen", bram_wen, last_push);
        if (hold_pend) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hold_val);
        end
        hold_pend = m_valid && !m_ready;
        hold_val  = m_data;
        if (bram_ren) begin
            chk("ren_nonempty", ram_m != 0, 1);
            chk("raddr", bram_raddr, rptr_m);
            rptr_m = rptr_m + 4'd1;
            ram_m--;
        end
        if (last_push) begin
            chk("waddr", bram_waddr, wptr_m);
            chk("wdata", bram_wdata, s_data);
            sb.push_back(s_data);
            wptr_m = wptr_m + 4'd1;
            ram_m++;
        end
        if (last_pop) begin
            if (sb.size() == 0) begin
                chk("pop_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("m_data", m_data, e);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        edge_adv();
        rst = 1'b0;
        sb.delete();
        wptr_m = '0;
        rptr_m = '0;
        ram_m = 0;
        hold_pend = 1'b0;
    endtask

    initial begin
        edge_adv();
        do_reset();

        // reset state and single-word latency
        samp();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ren", bram_ren, 0);
        edge_adv();
        s_valid = 1'b1; s_data = 32'hA5A5A5A5; m_ready = 1'b1;
        samp(); edge_adv();
        s_valid = 1'b0;
        samp();
        chk("lat_ren", bram_ren, 1);
        chk("lat_raddr", bram_raddr, 0);
        chk("lat_mv1", m_valid, 0);
        edge_adv();
        samp(); chk("lat_mv2", m_valid, 0); chk("lat_cnt2", count, 1); edge_adv();
        samp(); chk("lat_mv3", m_valid, 1); chk("lat_data", m_data, 32'hA5A5A5A5); edge_adv();
        samp(); chk("lat_cnt0", count, 0); edge_adv();

        // fill to DEPTH+2 with consumer stalled
        do_reset();
        s_valid = 1'b1; s_data = '0; acc = 0;
        for (int i = 0; i < 60 && acc < 18; i++) begin
            samp();
            if (last_push) acc++;
            edge_adv();
            s_data = acc;
        end
        chk("fill_acc", acc, 18);
        for (int i = 0; i < 4; i++) begin samp(); edge_adv(); end
        samp();
        chk("fill_s_ready", s_ready, 0);
        chk("fill_count", count, 18);
        chk("fill_no_wen", bram_wen, 0);
        edge_adv();

        // full throughput from full
        m_ready = 1'b1; nxt = acc; s_data = nxt;
        for (int i = 0; i < 30; i++) begin
            samp();
            if (i >= 1) begin
                chk("tp_push", last_push, 1);
                chk("tp_pop", last_pop, 1);
            end
            if (last_push) nxt++;
            edge_adv();
            s_data = nxt;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin samp(); edge_adv(); end
        chk("tp_drained", sb.size(), 0);

        // 40 words with random backpressure
        do_reset();
        s_valid = 1'b1; s_data = '0; acc = 0;
        for (int i = 0; i < 400 && (acc < 40 || sb.size() > 0); i++) begin
            m_ready = 1'($urandom_range(0, 1));
            samp();
            if (last_push) acc++;
            edge_adv();
            s_data = acc;
            if (acc == 40) s_valid = 1'b0;
        end
        chk("rnd_acc", acc, 40);
        chk("rnd_empty", sb.size(), 0);
        samp();
        chk("rnd_waddr_wrap", bram_waddr, 8);
        chk("rnd_raddr_wrap", bram_raddr, 8);
        edge_adv();

        // reset while a RAM read is in flight
        do_reset();
        s_valid = 1'b1; acc = 0; s_data = 32'd100;
        for (int i = 0; i < 20 && acc < 5; i++) begin
            samp();
            if (last_push) acc++;
            edge_adv();
            s_data = 32'd100 + acc;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin samp(); edge_adv(); end
        m_ready = 1'b1;
        samp(); chk("rm_ren", bram_ren, 1); edge_adv();
        do_reset();
        samp(); chk("rm_count", count, 0); chk("rm_mvalid", m_valid, 0); edge_adv();
        for (int i = 0; i < 3; i++) begin samp(); chk("rm_idle", m_valid, 0); edge_adv(); end
        s_valid = 1'b1; s_data = 32'h1; m_ready = 1'b1;
        samp(); edge_adv();
        s_valid = 1'b0;
        samp(); chk("rm_mv1", m_valid, 0); edge_adv();
        samp(); chk("rm_mv2", m_valid, 0); edge_adv();
        samp(); chk("rm_mv3", m_valid, 1); chk("rm_data", m_data, 32'h1); edge_adv();

        // alternate single push/pop on an empty FIFO
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = 32'h200 + k;
            samp(); edge_adv();
            s_valid = 1'b0;
            samp(); chk("alt_mv1", m_valid, 0); edge_adv();
            samp(); chk("alt_mv2", m_valid, 0); edge_adv();
            samp(); chk("alt_mv3", m_valid, 1); chk("alt_data", m_data, 32'h200 + k); edge_adv();
        end
        samp(); chk("alt_empty", count, 0); edge_adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
